key_led_array: RTL and testbench
================================

# key_led_array

Parametrised multi-channel push-button front end for the board-level LED demos. Each channel synchronises and debounces one raw key and detects presses. It advances a 4-state per-channel LED mode (off / on / slow blink / fast blink) and drives the LED from that mode. All channels share one blink timebase. The block sits between the board key pins and LED pins, and also exports its per-channel mode and press strobes to other logic.

## Interface
- N_CH, 4: number of key/LED channels (1..16)
- DB_CYC, 1_000_000: debounce window in clk cycles (20 ms at 50 MHz); must be ≥ 2
- BLINK_CYC, 25_000_000: slow-blink half-period in cycles; must be ≥ 4 and divisible by 4
- LONG_CYC, 100_000_000: long-press threshold in cycles; used only with the long-press feature
- KEY_ACTIVE_LOW, 1: 1 = a pressed key reads 0 at the pin
- clk  in  1  single system clock, rising edge
- rst  in  1  reset, asynchronous assert, active-high
- key  in  N_CH  raw, asynchronous key pins
- led  out  N_CH  LED drive, 1 = lit
- mode  out  2*N_CH  per-channel mode; channel i uses bits [2i+1:2i]
- press_pulse  out  N_CH  one-cycle strobe per accepted press
- long_pulse  out  N_CH  one-cycle strobe per accepted long press; constant 0 when the long-press feature is compiled out

## Operation
- Synchroniser: 2-flop per channel. Each flop resets to the released level (1 when KEY_ACTIVE_LOW=1).
- Debounce, per channel:
  - Registers: `stable` level and counter `dcnt`, width $clog2(DB_CYC+1).
  - While the synchronised sample equals `stable`, dcnt holds at 0.
  - While they differ, dcnt increments each cycle.
  - At DB_CYC consecutive differing samples, `stable` takes the sample value and dcnt returns to 0.
  - A single matching sample before that point (a bounce) clears dcnt.
- A press is a `stable` transition from released to pressed. It raises press_pulse[i] for exactly one cycle. A transition to released raises no strobe.
- Mode encoding: OFF=0, ON=1, SLOW=2, FAST=3. Each press advances the mode by 1, and 3 wraps to 0.
- Blink timebase: one shared counter wraps every BLINK_CYC cycles.
  - `slow_ph` toggles at each wrap.
  - `fast_ph` toggles every BLINK_CYC/4 cycles.
  - Both phases start at 0 after reset.
- LED, registered: OFF→0, ON→1, SLOW→slow_ph, FAST→fast_ph.
- Channels are fully independent. Simultaneous presses on several channels each advance their own mode in the same cycle.

## Timing
- Reset values: led=0, mode=0 (all channels), press_pulse=0, long_pulse=0, dcnt=0, stable=released, blink counter and both phases 0.
- Press latency: a key held steadily from its first pressed sample at edge k → press_pulse and the new mode are visible after edge k+2+DB_CYC. The led update follows one cycle later.
- Reset mid-debounce discards the partial count.
- A key held through reset deassertion is debounced again and counts as a fresh press, DB_CYC+2 cycles after release of rst.
- A press landing on the same edge as a blink wrap uses the new phase on the following led update. There is no glitch.

## Configuration
- Macro: KEY_LED_LONG_PRESS_EN.
- Defined:
  - A per-channel hold counter, width $clog2(LONG_CYC+1), counts while `stable` is pressed and clears on release.
  - When it reaches LONG_CYC, it forces mode to OFF and raises long_pulse[i] for one cycle.
  - It then saturates, so there is one strobe per hold.
  - The press that started the hold has already advanced the mode, and the long press overrides it.
- Undefined: no hold counters are built, long_pulse is tied to 0, and LONG_CYC is ignored.

## Structure
- Package key_led_pkg: mode encoding constants (MODE_OFF, MODE_ON, MODE_SLOW, MODE_FAST) and the 2-bit mode typedef.
- Sub-module key_debounce: one instance per channel, holding the synchroniser, debounce counter, stable level, press strobe and optional hold counter.
- The top level holds the mode registers, the shared blink timebase and the led registers.

## Test plan
All scenarios use N_CH=4, DB_CYC=4, BLINK_CYC=8, LONG_CYC=20, active-low keys.
- Clean press: key[0] driven 0 at edge 10 → press_pulse[0]=1 for one cycle after edge 16, mode[1:0]=1, led[0]=1 one cycle later.
- Bounce: key[1] low 3 cycles, high 1, low 3, then high → no press_pulse and mode[3:2] stays 0. A later low held for 4+ cycles produces exactly one pulse.
- Wrap and blink:
  - Four presses on ch2 step mode[5:4] through 1→2→3→0.
  - In SLOW, led[2] toggles every 8 cycles; in FAST, every 2 cycles.
  - ch2 and ch3 in SLOW together blink in phase.
- Simultaneous: all four keys pressed on the same cycle → press_pulse=4'hF for one cycle and all modes=1.
- Reset mid-operation: assert rst while ch0 is in FAST with dcnt=2 → led, mode and strobes are all 0 immediately. Keeping the key held across release of rst gives a press pulse DB_CYC+2 cycles later.
- With KEY_LED_LONG_PRESS_EN: hold key[3] for 40 cycles → one press_pulse (mode=1), then one long_pulse 20 cycles after stable press, mode=0. No further strobes until release and re-press.

Source files
------------

// File: rtl/key_led_pkg.sv
// Shared mode encoding for the key/LED front end.
package key_led_pkg;
  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF  = 2'd0;
  localparam mode_t MODE_ON   = 2'd1;
  localparam mode_t MODE_SLOW = 2'd2;
  localparam mode_t MODE_FAST = 2'd3;
endpackage

// File: rtl/key_debounce.sv
// One key channel: 2-flop synchroniser, debounce, press strobe and, with
// KEY_LED_LONG_PRESS_EN defined, a saturating hold counter for long presses.
module key_debounce
  import key_led_pkg::*;
#(
  parameter int DB_CYC         = 1_000_000,
  parameter int LONG_CYC       = 100_000_000,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key,
  output logic o_press,
  output logic o_press_nxt,
  output logic o_long,
  output logic o_long_nxt
);
  localparam logic REL = (KEY_ACTIVE_LOW != 0);
  localparam int   DCW = $clog2(DB_CYC + 1);

  logic           r_sync1, r_sync2, r_stable, r_stable_d, r_press;
  logic [DCW-1:0] r_dcnt;

  // o_press_nxt lets the mode register advance on the same edge the strobe rises
  assign o_press_nxt = (r_stable != REL) && (r_stable_d == REL);
  assign o_press     = r_press;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1    <= REL;
      r_sync2    <= REL;
      r_stable   <= REL;
      r_stable_d <= REL;
      r_press    <= 1'b0;
      r_dcnt     <= '0;
    end else begin
      r_sync1    <= i_key;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      r_press    <= o_press_nxt;
      if (r_sync2 == r_stable) begin
        r_dcnt <= '0;
      end else if (r_dcnt == DCW'(DB_CYC - 1)) begin
        r_stable <= r_sync2;
        r_dcnt   <= '0;
      end else begin
        r_dcnt <= r_dcnt + 1'b1;
      end
    end
  end

`ifdef KEY_LED_LONG_PRESS_EN
  localparam int HCW = $clog2(LONG_CYC + 1);

  logic [HCW-1:0] r_hold;
  logic           r_long;

  assign o_long_nxt = (r_stable != REL) && (r_hold == HCW'(LONG_CYC - 1));
  assign o_long     = r_long;

  // Saturating at LONG_CYC gives exactly one strobe per hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold <= '0;
      r_long <= 1'b0;
    end else begin
      r_long <= o_long_nxt;
      if (r_stable == REL)
        r_hold <= '0;
      else if (r_hold != HCW'(LONG_CYC))
        r_hold <= r_hold + 1'b1;
    end
  end
`else
  logic w_unused_long;
  assign w_unused_long = (LONG_CYC > 0);
  assign o_long_nxt    = 1'b0;
  assign o_long        = 1'b0;
`endif
endmodule

// File: rtl/key_led_array.sv
// Multi-channel key -> LED mode front end with a shared blink timebase.
// Long-press support is compiled in with KEY_LED_LONG_PRESS_EN.
module key_led_array
  import key_led_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int DB_CYC         = 1_000_000,
  parameter int BLINK_CYC      = 25_000_000,
  parameter int LONG_CYC       = 100_000_000,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH-1:0]     key,
  output logic [N_CH-1:0]     led,
  output logic [2*N_CH-1:0]   mode,
  output logic [N_CH-1:0]     press_pulse,
  output logic [N_CH-1:0]     long_pulse
);
  localparam int QTR = BLINK_CYC / 4;
  localparam int QW  = (QTR > 1) ? $clog2(QTR) : 1;

  logic  [N_CH-1:0] w_adv, w_clr;
  mode_t [N_CH-1:0] r_mode;
  logic  [N_CH-1:0] r_led;
  logic  [QW-1:0]   r_qcnt;
  logic  [1:0]      r_qidx;
  logic             r_slow_ph, r_fast_ph;
  logic             w_qwrap;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    key_debounce #(
      .DB_CYC        (DB_CYC),
      .LONG_CYC      (LONG_CYC),
      .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
    ) u_db (
      .clk        (clk),
      .rst        (rst),
      .i_key      (key[g]),
      .o_press    (press_pulse[g]),
      .o_press_nxt(w_adv[g]),
      .o_long     (long_pulse[g]),
      .o_long_nxt (w_clr[g])
    );
  end

  // Quarter-period counter plus a 2-bit quarter index: the full wrap is the
  // fourth quarter, so no modulo of BLINK_CYC is needed.
  assign w_qwrap = (r_qcnt == QW'(QTR - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_qcnt    <= '0;
      r_qidx    <= '0;
      r_slow_ph <= 1'b0;
      r_fast_ph <= 1'b0;
    end else if (w_qwrap) begin
      r_qcnt    <= '0;
      r_qidx    <= r_qidx + 2'd1;
      r_fast_ph <= ~r_fast_ph;
      if (r_qidx == 2'd3) r_slow_ph <= ~r_slow_ph;
    end else begin
      r_qcnt <= r_qcnt + 1'b1;
    end
  end

  // A long press overrides any advance landing on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode <= '0;
      r_led  <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (w_clr[i])      r_mode[i] <= MODE_OFF;
        else if (w_adv[i]) r_mode[i] <= r_mode[i] + 2'd1;
        case (r_mode[i])
          MODE_OFF:  r_led[i] <= 1'b0;
          MODE_ON:   r_led[i] <= 1'b1;
          MODE_SLOW: r_led[i] <= r_slow_ph;
          default:   r_led[i] <= r_fast_ph;
        endcase
      end
    end
  end

  assign mode = r_mode;
  assign led  = r_led;
endmodule

// File: tb/tb_key_led_array.sv
// Directed + random bench for key_led_array against a sliding-window reference model.
module tb_key_led_array;
  localparam int N_CH = 4;
  localparam int DB   = 4;
  localparam int BL   = 8;
  localparam int LG   = 20;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N_CH-1:0]   key = '1;
  logic [N_CH-1:0]   led, press_pulse, long_pulse;
  logic [2*N_CH-1:0] mode;

  always #5 clk = ~clk;

  key_led_array #(
    .N_CH(N_CH), .DB_CYC(DB), .BLINK_CYC(BL), .LONG_CYC(LG), .KEY_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .key(key), .led(led), .mode(mode),
    .press_pulse(press_pulse), .long_pulse(long_pulse)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: history of pressed samples per edge since reset release
  int                cyc;
  bit                hist [N_CH][4096];
  bit                stbl [N_CH];
  int                mmode[N_CH];
  bit                pend [N_CH];
  int                age  [N_CH];
  logic [N_CH-1:0]   e_press, e_long, e_led;
  logic [2*N_CH-1:0] e_mode;
  int                rem  [N_CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic void model_reset();
    cyc = 0;
    for (int c = 0; c < N_CH; c++) begin
      stbl[c] = 1'b0; mmode[c] = 0; pend[c] = 1'b0; age[c] = 0;
    end
    e_press = '0; e_long = '0; e_led = '0; e_mode = '0;
  endfunction

  function automatic bit samp(input int c, input int t);
    return (t >= 1) ? hist[c][t] : 1'b0;
  endfunction

  task automatic model_edge();
    cyc++;
    if (cyc >= 4096) begin
      $display("FAIL model_range cyc=%0d", cyc);
      $fatal(1);
    end
    for (int c = 0; c < N_CH; c++) begin
      int  sl, fs;
      bit  diff;
      sl = ((cyc - 1) / BL) % 2;
      fs = ((cyc - 1) / (BL / 4)) % 2;
      e_led[c] = (mmode[c] == 1) || (mmode[c] == 2 && sl == 1) || (mmode[c] == 3 && fs == 1);
      hist[c][cyc] = !key[c];
      e_press[c] = pend[c];
      if (pend[c]) mmode[c] = (mmode[c] + 1) % 4;
      pend[c] = 1'b0;
      e_long[c] = 1'b0;
`ifdef KEY_LED_LONG_PRESS_EN
      if (stbl[c]) begin
        age[c]++;
        if (age[c] == LG) begin
          e_long[c] = 1'b1;
          mmode[c]  = 0;
        end
      end else begin
        age[c] = 0;
      end
`endif
      // stable flips once the last DB synchronised samples all disagree with it
      diff = 1'b1;
      for (int j = 0; j < DB; j++)
        if (samp(c, cyc - 2 - j) == stbl[c]) diff = 1'b0;
      if (diff) begin
        stbl[c] = ~stbl[c];
        if (stbl[c]) begin
          pend[c] = 1'b1;
          age[c]  = 0;
        end
      end
      e_mode[2*c +: 2] = 2'(mmode[c]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("press_pulse", 32'(press_pulse), 32'(e_press));
    check("long_pulse",  32'(long_pulse),  32'(e_long));
    check("mode",        32'(mode),        32'(e_mode));
    check("led",         32'(led),         32'(e_led));
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    #1;
    check("rst_led",   32'(led),         32'd0);
    check("rst_mode",  32'(mode),        32'd0);
    check("rst_press", 32'(press_pulse), 32'd0);
    check("rst_long",  32'(long_pulse),  32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic press_ch(input int c);
    key[c] = 1'b0; hold(7);
    key[c] = 1'b1; hold(7);
  endtask

  initial begin
    model_reset();
    key = '1;
    repeat (3) @(posedge clk);
    #1;
    reset_dut();

    // Clean press on ch0: key present from edge 10, strobe after edge 16
    hold(9);
    key[0] = 1'b0;
    hold(6);
    check("clean_pre",   32'(press_pulse[0]), 32'd0);
    tick();
    check("clean_press", 32'(press_pulse[0]), 32'd1);
    check("clean_mode",  32'(mode[1:0]),      32'd1);
    tick();
    check("clean_led",   32'(led[0]),         32'd1);
    check("clean_once",  32'(press_pulse[0]), 32'd0);
    key[0] = 1'b1; hold(8);

    // Bounce on ch1 must be rejected; a clean hold afterwards is one press
    key[1] = 1'b0; hold(3);
    key[1] = 1'b1; hold(1);
    key[1] = 1'b0; hold(3);
    key[1] = 1'b1; hold(8);
    check("bounce_mode", 32'(mode[3:2]), 32'd0);
    press_ch(1);
    check("bounce_later", 32'(mode[3:2]), 32'd1);

    // ch2 steps through all modes; ch3 follows into SLOW to compare phase
    for (int p = 0; p < 4; p++) begin
      key[2] = 1'b0;
      if (p < 2) key[3] = 1'b0;
      hold(7);
      key[2] = 1'b1; key[3] = 1'b1;
      hold(7);
      check("wrap_mode", 32'(mode[5:4]), 32'((p + 1) % 4));
      if (p == 1) begin
        for (int i = 0; i < 20; i++) begin
          tick();
          check("inphase", 32'(led[2]), 32'(led[3]));
        end
      end
      if (p == 2) hold(12);
    end
    press_ch(3); press_ch(3);

    // Simultaneous press on all channels from a clean reset
    reset_dut();
    hold(4);
    key = '0;
    hold(6);
    check("simul_pre",  32'(press_pulse), 32'd0);
    tick();
    check("simul",      32'(press_pulse), 32'hF);
    check("simul_mode", 32'(mode),        32'h55);
    tick();
    check("simul_once", 32'(press_pulse), 32'd0);
    key = '1; hold(8);

    // Random key activity, including bounce-length pulses
    for (int c = 0; c < N_CH; c++) rem[c] = 0;
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (rem[c] == 0) begin
          key[c] = 1'($urandom_range(0, 1));
          rem[c] = int'($urandom_range(1, 9));
        end
        rem[c]--;
      end
      tick();
    end
    key = '1; hold(10);

    // Reset mid-debounce with ch0 in FAST, key held across reset release
    for (int i = 0; i < 4; i++) if (mmode[0] != 3) press_ch(0);
    check("fast_mode", 32'(mode[1:0]), 32'd3);
    hold(6);
    key[0] = 1'b0;
    hold(4);
    #2;
    reset_dut();
    hold(6);
    check("rst_held_pre", 32'(press_pulse[0]), 32'd0);
    tick();
    check("rst_held_press", 32'(press_pulse[0]), 32'd1);
    key[0] = 1'b1; hold(8);

`ifdef KEY_LED_LONG_PRESS_EN
    begin
      int np, nl;
      np = 0; nl = 0;
      key[3] = 1'b0;
      for (int i = 0; i < 40; i++) begin
        tick();
        np += int'(press_pulse[3]);
        nl += int'(long_pulse[3]);
      end
      check("long_presses", 32'(np), 32'd1);
      check("long_count",   32'(nl), 32'd1);
      check("long_mode",    32'(mode[7:6]), 32'd0);
      key[3] = 1'b1; hold(10);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
